// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: RV32 instruction decode pipeline stage.
// Accepts {instr, pc} from fetch over valid/ready and presents the decoded
// fields one cycle later through an output register. A one-entry skid
// register absorbs the single instruction that can arrive while the consumer
// stalls. This keeps in_ready a pure register output.

package riscv_decode_pkg;

   // Major opcodes, instr[6:0]
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RI     = 7'b0010011;
   localparam logic [6:0] OP_RR     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_EXCPT  = 7'b1110011;

   // Bit positions inside the one-hot opcode class vector
   localparam int OH_LUI    = 10;
   localparam int OH_AUIPC  = 9;
   localparam int OH_JAL    = 8;
   localparam int OH_JALR   = 7;
   localparam int OH_BRANCH = 6;
   localparam int OH_LOAD   = 5;
   localparam int OH_STORE  = 4;
   localparam int OH_RI     = 3;
   localparam int OH_RR     = 2;
   localparam int OH_FENCE  = 1;
   localparam int OH_EXCPT  = 0;

   typedef enum logic [2:0] {
      FMT_R    = 3'b000,
      FMT_I    = 3'b001,
      FMT_S    = 3'b010,
      FMT_B    = 3'b011,
      FMT_U    = 3'b100,
      FMT_J    = 3'b101,
      FMT_NONE = 3'b111
   } fmt_e;

endpackage

module riscv_decode_stage
   import riscv_decode_pkg::*;
#(
   parameter int              XLEN     = 32,          // only 32 is supported
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [10:0]     out_opcode_1hot,
   output logic [2:0]      out_fmt,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [XLEN-1:0] out_imm,
   output logic            out_illegal
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [10:0]     opcode_1hot;
      fmt_e            fmt;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } payload_t;

   payload_t dec;
   payload_t or_data;
   payload_t sk_data;
   logic     or_valid;
   logic     sk_valid;
   logic     in_ready_q;

   logic     accept;
   logic     or_free;
   logic     or_valid_n;
   logic     sk_valid_n;
   logic     load_or_from_sk;
   logic     load_or_from_in;
   logic     load_sk;

   // Decode the incoming instruction into a payload (pure combinational)
   always_comb begin
      // NOTE: combinational blocks use blocking '=' and give every output a
      // default first, so no path leaves a variable unassigned (no latch).
      dec             = '0;
      dec.pc          = in_pc;
      dec.fmt         = FMT_NONE;
      dec.rd          = in_instr[11:7];
      dec.rs1         = in_instr[19:15];
      dec.rs2         = in_instr[24:20];
      dec.funct3      = in_instr[14:12];
      dec.funct7      = in_instr[31:25];
      dec.illegal     = 1'b0;

      // Every valid opcode ends in 2'b11, so a word with other low bits
      // falls into the default arm and is flagged illegal.
      case (in_instr[6:0])
         OP_LUI:    begin dec.opcode_1hot[OH_LUI]    = 1'b1; dec.fmt = FMT_U; end
         OP_AUIPC:  begin dec.opcode_1hot[OH_AUIPC]  = 1'b1; dec.fmt = FMT_U; end
         OP_JAL:    begin dec.opcode_1hot[OH_JAL]    = 1'b1; dec.fmt = FMT_J; end
         OP_JALR:   begin dec.opcode_1hot[OH_JALR]   = 1'b1; dec.fmt = FMT_I; end
         OP_BRANCH: begin dec.opcode_1hot[OH_BRANCH] = 1'b1; dec.fmt = FMT_B; end
         OP_LOAD:   begin dec.opcode_1hot[OH_LOAD]   = 1'b1; dec.fmt = FMT_I; end
         OP_STORE:  begin dec.opcode_1hot[OH_STORE]  = 1'b1; dec.fmt = FMT_S; end
         OP_RI:     begin dec.opcode_1hot[OH_RI]     = 1'b1; dec.fmt = FMT_I; end
         OP_RR:     begin dec.opcode_1hot[OH_RR]     = 1'b1; dec.fmt = FMT_R; end
         OP_FENCE:  begin dec.opcode_1hot[OH_FENCE]  = 1'b1; dec.fmt = FMT_I; end
         OP_EXCPT:  begin dec.opcode_1hot[OH_EXCPT]  = 1'b1; dec.fmt = FMT_I; end
         default:   dec.illegal = 1'b1;
      endcase

      case (dec.fmt)
         FMT_I:   dec.imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
         FMT_S:   dec.imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         FMT_B:   dec.imm = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
         FMT_U:   dec.imm = {in_instr[31:12], 12'b0};
         FMT_J:   dec.imm = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
         default: dec.imm = '0;
      endcase
   end

   assign accept  = in_valid && in_ready_q;
   assign or_free = !or_valid || out_ready;

   // Next-state for the output/skid valid bits and which payload moves where
   always_comb begin
      or_valid_n      = or_valid;
      sk_valid_n      = sk_valid;
      load_or_from_sk = 1'b0;
      load_or_from_in = 1'b0;
      load_sk         = 1'b0;
      if (or_free) begin
         // Skid entry is older than anything on the input, so it goes first.
         // While it is valid in_ready is low, so no accept can coincide.
         if (sk_valid) begin
            load_or_from_sk = 1'b1;
            or_valid_n      = 1'b1;
            sk_valid_n      = 1'b0;
         end else if (accept) begin
            load_or_from_in = 1'b1;
            or_valid_n      = 1'b1;
         end else begin
            or_valid_n      = 1'b0;
         end
      end else if (accept) begin
         load_sk    = 1'b1;
         sk_valid_n = 1'b1;
      end
   end

   // Control state and output payload: reset beats flush beats handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         or_valid       <= 1'b0;
         sk_valid       <= 1'b0;
         in_ready_q     <= 1'b1;
         or_data        <= '0;
         or_data.pc     <= RESET_PC;
         or_data.fmt    <= FMT_NONE;
      end else if (flush) begin
         or_valid       <= 1'b0;
         sk_valid       <= 1'b0;
         in_ready_q     <= 1'b1;
      end else begin
         or_valid       <= or_valid_n;
         sk_valid       <= sk_valid_n;
         in_ready_q     <= !sk_valid_n;
         if (load_or_from_sk) begin
            or_data <= sk_data;
         end else if (load_or_from_in) begin
            or_data <= dec;
         end
      end
   end

   // Skid payload capture while the output register is stalled
   always_ff @(posedge clk) begin
      // NOTE: the skid payload has no reset; it is only ever read when
      // sk_valid is set, and sk_valid itself is reset above.
      if (!rst && !flush && load_sk) begin
         sk_data <= dec;
      end
   end

   assign in_ready        = in_ready_q;
   assign out_valid       = or_valid;
   assign out_pc          = or_data.pc;
   assign out_opcode_1hot = or_data.opcode_1hot;
   assign out_fmt         = or_data.fmt;
   assign out_rd          = or_data.rd;
   assign out_rs1         = or_data.rs1;
   assign out_rs2         = or_data.rs2;
   assign out_funct3      = or_data.funct3;
   assign out_funct7      = or_data.funct7;
   assign out_imm         = or_data.imm;
   assign out_illegal     = or_data.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Self-checking bench for riscv_decode_stage: directed cases followed by
// randomized traffic compared against a queue-based reference model.
module tb_riscv_decode_stage;

   localparam logic [31:0] RST_PC = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [10:0] out_opcode_1hot;
   logic [2:0]  out_fmt;
   logic [4:0]  out_rd;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;
   logic [31:0] out_imm;
   logic        out_illegal;

   riscv_decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_opcode_1hot(out_opcode_1hot), .out_fmt(out_fmt),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_funct3(out_funct3), .out_funct7(out_funct7),
      .out_imm(out_imm), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [10:0] oh;
      logic [2:0]  fmt;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic        ill;
   } exp_t;

   exp_t q[$];          // instructions in flight, oldest first
   int   n_checks = 0;
   int   n_errors = 0;
   logic last_acc = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference decode written from the ISA field rules using integer arithmetic
   function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
      exp_t e;
      int   s;
      s     = instr;
      e.pc  = pc;
      e.rd  = instr[11:7];
      e.rs1 = instr[19:15];
      e.rs2 = instr[24:20];
      e.f3  = instr[14:12];
      e.f7  = instr[31:25];
      e.oh  = 11'h000;
      e.fmt = 3'd7;
      e.ill = 1'b0;
      case (instr[6:0])
         7'h37: begin e.oh = 11'h400; e.fmt = 3'd4; end
         7'h17: begin e.oh = 11'h200; e.fmt = 3'd4; end
         7'h6F: begin e.oh = 11'h100; e.fmt = 3'd5; end
         7'h67: begin e.oh = 11'h080; e.fmt = 3'd1; end
         7'h63: begin e.oh = 11'h040; e.fmt = 3'd3; end
         7'h03: begin e.oh = 11'h020; e.fmt = 3'd1; end
         7'h23: begin e.oh = 11'h010; e.fmt = 3'd2; end
         7'h13: begin e.oh = 11'h008; e.fmt = 3'd1; end
         7'h33: begin e.oh = 11'h004; e.fmt = 3'd0; end
         7'h0F: begin e.oh = 11'h002; e.fmt = 3'd1; end
         7'h73: begin e.oh = 11'h001; e.fmt = 3'd1; end
         default: e.ill = 1'b1;
      endcase
      case (e.fmt)
         3'd1:    e.imm = s >>> 20;
         3'd2:    e.imm = ((s >>> 25) << 5) | ((s >>> 7) & 31);
         3'd3:    e.imm = ((s >>> 31) << 12) | (((s >>> 7) & 1) << 11)
                        | (((s >>> 25) & 63) << 5) | (((s >>> 8) & 15) << 1);
         3'd4:    e.imm = instr & 32'hFFFF_F000;
         3'd5:    e.imm = ((s >>> 31) << 20) | (((s >>> 12) & 255) << 12)
                        | (((s >>> 20) & 1) << 11) | (((s >>> 21) & 1023) << 1);
         default: e.imm = 32'h0;
      endcase
      return e;
   endfunction

   // One clock: compare outputs mid-cycle against the model, then advance the model
   task automatic cycle();
      logic acc;
      logic drn;
      exp_t e;
      @(negedge clk);
      check("out_valid", out_valid, q.size() > 0);
      check("in_ready", in_ready, q.size() < 2);
      if (q.size() > 0) begin
         e = q[0];
         check("out_pc", out_pc, e.pc);
         check("out_opcode_1hot", out_opcode_1hot, e.oh);
         check("out_fmt", out_fmt, e.fmt);
         check("out_rd", out_rd, e.rd);
         check("out_rs1", out_rs1, e.rs1);
         check("out_rs2", out_rs2, e.rs2);
         check("out_funct3", out_funct3, e.f3);
         check("out_funct7", out_funct7, e.f7);
         check("out_imm", out_imm, e.imm);
         check("out_illegal", out_illegal, e.ill);
      end
      acc = in_valid && (q.size() < 2);
      drn = out_ready && (q.size() > 0);
      @(posedge clk);
      last_acc = 1'b0;
      if (rst || flush) begin
         q.delete();
      end else begin
         if (drn) void'(q.pop_front());
         if (acc) begin
            q.push_back(ref_decode(in_instr, in_pc));
            last_acc = 1'b1;
         end
      end
      #1;
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] pc);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
      cycle();
      in_valid = 1'b0;
   endtask

   logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                             7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

   initial begin
      logic [31:0] r;
      int          k;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = 32'h0; in_pc = 32'h0;
      cycle();
      cycle();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_pc", out_pc, RST_PC);
      check("rst_out_fmt", out_fmt, 3'b111);
      check("rst_out_imm", out_imm, 32'h0);
      check("rst_out_opcode", out_opcode_1hot, 11'h000);
      rst = 1'b0;
      cycle();

      // addi x1,x0,5
      out_ready = 1'b1;
      push(32'h0050_0093, 32'h0000_0100);
      check("addi_valid", out_valid, 1'b1);
      check("addi_oh", out_opcode_1hot, 11'h008);
      check("addi_fmt", out_fmt, 3'b001);
      check("addi_rd", out_rd, 5'd1);
      check("addi_rs1", out_rs1, 5'd0);
      check("addi_imm", out_imm, 32'h0000_0005);
      check("addi_ill", out_illegal, 1'b0);

      // lui then beq back-to-back at full rate
      in_valid = 1'b1; in_instr = 32'h1234_5137; in_pc = 32'h0000_0200;
      cycle();
      check("lui_oh", out_opcode_1hot, 11'h400);
      check("lui_fmt", out_fmt, 3'b100);
      check("lui_imm", out_imm, 32'h1234_5000);
      check("lui_in_ready", in_ready, 1'b1);
      in_instr = 32'hFE00_0EE3; in_pc = 32'h0000_0204;
      cycle();
      in_valid = 1'b0;
      check("beq_valid", out_valid, 1'b1);
      check("beq_pc", out_pc, 32'h0000_0204);
      check("beq_oh", out_opcode_1hot, 11'h040);
      check("beq_fmt", out_fmt, 3'b011);
      check("beq_imm", out_imm, 32'hFFFF_FFFC);

      // sw x5,8(x2) and an all-ones word
      push(32'h0051_2423, 32'h0000_0208);
      check("sw_oh", out_opcode_1hot, 11'h010);
      check("sw_fmt", out_fmt, 3'b010);
      check("sw_rs1", out_rs1, 5'd2);
      check("sw_rs2", out_rs2, 5'd5);
      check("sw_f3", out_funct3, 3'b010);
      check("sw_imm", out_imm, 32'h0000_0008);
      push(32'hFFFF_FFFF, 32'h0000_020C);
      check("ill_flag", out_illegal, 1'b1);
      check("ill_fmt", out_fmt, 3'b111);
      check("ill_oh", out_opcode_1hot, 11'h000);
      check("ill_imm", out_imm, 32'h0);
      cycle();

      // Backpressure: A held, B in skid, C waits at fetch
      out_ready = 1'b0;
      push(32'h0010_0093, 32'h0000_0300);
      push(32'h0020_0113, 32'h0000_0304);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_hold_A", out_pc, 32'h0000_0300);
      in_valid = 1'b1; in_instr = 32'h0030_0193; in_pc = 32'h0000_0308;
      cycle();
      check("bp_still_A", out_pc, 32'h0000_0300);
      out_ready = 1'b1;
      cycle();
      check("bp_then_B", out_pc, 32'h0000_0304);
      check("bp_ready_back", in_ready, 1'b1);
      cycle();
      in_valid = 1'b0;
      check("bp_then_C", out_pc, 32'h0000_0308);
      cycle();
      check("bp_drained", out_valid, 1'b0);

      // Flush with both registers full and an incoming instruction
      out_ready = 1'b0;
      push(32'h0040_0213, 32'h0000_0400);
      push(32'h0050_0293, 32'h0000_0404);
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0060_0313; in_pc = 32'h0000_0408;
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_valid", out_valid, 1'b0);
      check("flush_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      repeat (3) cycle();

      // Reset mid-stream with the consumer stalled
      out_ready = 1'b0;
      push(32'h0070_0393, 32'h0000_0500);
      push(32'h0080_0413, 32'h0000_0504);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("mrst_valid", out_valid, 1'b0);
      check("mrst_ready", in_ready, 1'b1);
      check("mrst_pc", out_pc, RST_PC);
      check("mrst_fmt", out_fmt, 3'b111);

      // Randomized traffic; fetch holds an unaccepted instruction stable
      for (int i = 0; i < 3000; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 49) == 0);
         rst       = ($urandom_range(0, 299) == 0);
         if (!in_valid || last_acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            r = $urandom();
            k = $urandom_range(0, 12);
            in_instr = (k < 11) ? {r[31:7], ops[k]} : r;
            in_pc    = $urandom() & 32'hFFFF_FFFC;
         end
         cycle();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) cycle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
